// File: rtl/renode_mem_initiator.sv
// Single-outstanding AXI4 manager that turns Renode-style bus commands into
// single-beat AXI4 reads/writes and returns data or completion with an error flag.

package renode_mem_initiator_pkg;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 8;
    localparam int unsigned UW = 1;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic          lock;
        logic [3:0]    cache;
        logic [2:0]    prot;
        logic [3:0]    qos;
        logic [3:0]    region;
        logic [UW-1:0] user;
    } ax_chan_t;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
        logic [UW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic [UW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [UW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } rsp_t;
endpackage

module renode_mem_initiator
    import renode_mem_initiator_pkg::*;
#(
    parameter int unsigned        AddrWidth = 64,
    parameter int unsigned        DataWidth = 64,
    parameter int unsigned        IdWidth   = 8,
    parameter logic [IdWidth-1:0] TxnId     = '0,
    parameter type                axi_req_t = req_t,
    parameter type                axi_rsp_t = rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [1:0]           cmd_size_i,
    input  logic [DataWidth-1:0] cmd_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 rsp_error_o,
    output axi_req_t             axi_req_o,
    input  axi_rsp_t             axi_rsp_i
);
    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_e;

    function automatic logic access_err(input logic [AddrWidth-1:0] addr,
                                        input logic [1:0] size);
        logic [AddrWidth-1:0] amask;
        amask = AddrWidth'((32'd1 << size) - 32'd1);
        return (32'(StrbW) < (32'd1 << size)) || ((addr & amask) != '0);
    endfunction

    function automatic logic [StrbW-1:0] strb_of(input logic [OffW-1:0] off,
                                                 input logic [1:0] size);
        logic [2*StrbW-1:0] s;
        s = (2*StrbW)'((32'd1 << (32'd1 << size)) - 32'd1) << off;
        return s[StrbW-1:0];
    endfunction

    function automatic logic [DataWidth-1:0] rdata_of(input logic [DataWidth-1:0] d,
                                                      input logic [OffW-1:0] off,
                                                      input logic [1:0] size);
        logic [DataWidth-1:0] m;
        m = '0;
        for (int i = 0; i < int'(StrbW); i++) begin
            if (i < (1 << size)) m[8*i +: 8] = 8'hFF;
        end
        return (d >> {off, 3'b000}) & m;
    endfunction

    state_e                 state_q;
    logic                   cmd_ready_q;
    logic                   aw_valid_q, w_valid_q, ar_valid_q;
    logic                   b_ready_q, r_ready_q;
    logic                   rsp_valid_q, rsp_err_q;
    logic [DataWidth-1:0]   rsp_data_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [1:0]             size_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [StrbW-1:0]       strb_q;

    logic [OffW-1:0]        cmd_off, off_q;
    logic [DataWidth-1:0]   wdata_d;
    logic [StrbW-1:0]       strb_d;
    logic                   cmd_err_d;
    logic                   aw_fire, w_fire;

    assign cmd_off   = cmd_addr_i[OffW-1:0];
    assign off_q     = addr_q[OffW-1:0];
    assign wdata_d   = cmd_data_i << {cmd_off, 3'b000};
    assign strb_d    = strb_of(cmd_off, cmd_size_i);
    assign cmd_err_d = access_err(cmd_addr_i, cmd_size_i);
    assign aw_fire   = aw_valid_q & axi_rsp_i.aw_ready;
    assign w_fire    = w_valid_q & axi_rsp_i.w_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_ready_q && cmd_valid_i) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr_i;
                        size_q      <= cmd_size_i;
                        wdata_q     <= wdata_d;
                        strb_q      <= strb_d;
                        if (cmd_err_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else if (cmd_write_i) begin
                            state_q    <= WR_ADDR_DATA;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                        end else begin
                            state_q    <= RD_ADDR;
                            ar_valid_q <= 1'b1;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                // A dropped valid doubles as the sticky "accepted" flag for its channel.
                WR_ADDR_DATA: begin
                    if (aw_fire) aw_valid_q <= 1'b0;
                    if (w_fire) w_valid_q <= 1'b0;
                    if ((aw_fire || !aw_valid_q) && (w_fire || !w_valid_q)) begin
                        state_q   <= WR_RESP;
                        b_ready_q <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (axi_rsp_i.b_valid) begin
                        b_ready_q   <= 1'b0;
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= axi_rsp_i.b.resp[1];
                        rsp_data_q  <= '0;
                    end
                end
                RD_ADDR: begin
                    if (axi_rsp_i.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_rsp_i.r_valid) begin
                        r_ready_q   <= 1'b0;
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= axi_rsp_i.r.resp[1] | ~axi_rsp_i.r.last;
                        rsp_data_q  <= rdata_of(axi_rsp_i.r.data, off_q, size_q);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= '0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_error_o = rsp_err_q;

    always_comb begin
        axi_req_o           = '0;
        axi_req_o.aw.id     = TxnId;
        axi_req_o.aw.addr   = addr_q;
        axi_req_o.aw.size   = {1'b0, size_q};
        axi_req_o.aw.burst  = 2'b01;
        axi_req_o.aw_valid  = aw_valid_q;
        axi_req_o.w.data    = wdata_q;
        axi_req_o.w.strb    = strb_q;
        axi_req_o.w.last    = 1'b1;
        axi_req_o.w_valid   = w_valid_q;
        axi_req_o.b_ready   = b_ready_q;
        axi_req_o.ar.id     = TxnId;
        axi_req_o.ar.addr   = addr_q;
        axi_req_o.ar.size   = {1'b0, size_q};
        axi_req_o.ar.burst  = 2'b01;
        axi_req_o.ar_valid  = ar_valid_q;
        axi_req_o.r_ready   = r_ready_q;
    end

    // Response IDs, user bits and the OKAY/EXOKAY distinction carry no meaning here.
    logic unused_rsp;
    assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.b.resp[0],
                          axi_rsp_i.r.id, axi_rsp_i.r.user, axi_rsp_i.r.resp[0]};

endmodule

// File: tb/tb_renode_mem_initiator.sv
// Bench for renode_mem_initiator: directed and random commands against a
// byte-level memory model, with a configurable-latency AXI subordinate.

module tb_renode_mem_initiator;
    import renode_mem_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [63:0] cmd_addr = '0;
    logic [1:0]  cmd_size = '0;
    logic [63:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    logic        rsp_error;
    req_t        axi_req;
    rsp_t        axi_rsp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    renode_mem_initiator dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write),
        .cmd_addr_i (cmd_addr),
        .cmd_size_i (cmd_size),
        .cmd_data_i (cmd_data),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data),
        .rsp_error_o(rsp_error),
        .axi_req_o  (axi_req),
        .axi_rsp_i  (axi_rsp)
    );

    // Subordinate configuration (written by stimulus) and observations (written by subordinate)
    int         cfg_aw_hold = 1, cfg_w_hold = 1, cfg_ar_hold = 1;
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic       cfg_rlast = 1'b1;

    ax_chan_t aw_prev, aw_cap, ar_prev, ar_cap;
    w_chan_t  w_prev, w_cap;
    logic     hs_aw, hs_w, hs_ar, hs_b, hs_r, got_aw, got_w, ar_acc;
    int       aw_cyc, w_cyc, ar_cyc;
    logic [7:0] smem [logic [63:0]];
    logic [7:0] mmem [logic [63:0]];

    function automatic logic [7:0] sget(input logic [63:0] a);
        return smem.exists(a) ? smem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] mget(input logic [63:0] a);
        return mmem.exists(a) ? mmem[a] : 8'h00;
    endfunction

    initial begin : subordinate
        logic [63:0] word;
        axi_rsp = '0;
        {hs_aw, hs_w, hs_ar, hs_b, hs_r, got_aw, got_w, ar_acc} = '0;
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
        aw_prev = '0; aw_cap = '0; ar_prev = '0; ar_cap = '0; w_prev = '0; w_cap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi_rsp = '0;
                {hs_aw, hs_w, hs_ar, hs_b, hs_r, got_aw, got_w} = '0;
                continue;
            end
            if (cmd_valid && cmd_ready) begin
                aw_cyc = 0; w_cyc = 0; ar_cyc = 0; ar_acc = 1'b0;
            end
            if (hs_b) axi_rsp.b_valid = 1'b0;
            if (hs_r) axi_rsp.r_valid = 1'b0;
            if (hs_aw) begin got_aw = 1'b1; aw_cap = aw_prev; end
            if (hs_w) begin got_w = 1'b1; w_cap = w_prev; end
            if (hs_ar) begin
                ar_cap = ar_prev;
                ar_acc = 1'b1;
                for (int i = 0; i < 8; i++)
                    word[8*i +: 8] = sget((ar_prev.addr & ~64'h7) + 64'(i));
                axi_rsp.r_valid = 1'b1;
                axi_rsp.r.data  = word;
                axi_rsp.r.resp  = cfg_rresp;
                axi_rsp.r.last  = cfg_rlast;
            end
            if (got_aw && got_w) begin
                if (!cfg_bresp[1])
                    for (int i = 0; i < 8; i++)
                        if (w_cap.strb[i]) smem[(aw_cap.addr & ~64'h7) + 64'(i)] = w_cap.data[8*i +: 8];
                axi_rsp.b_valid = 1'b1;
                axi_rsp.b.resp  = cfg_bresp;
                got_aw = 1'b0;
                got_w  = 1'b0;
            end
            if (axi_req.aw_valid) aw_cyc++;
            if (axi_req.w_valid) w_cyc++;
            if (axi_req.ar_valid) ar_cyc++;
            axi_rsp.aw_ready = axi_req.aw_valid && (aw_cyc >= cfg_aw_hold);
            axi_rsp.w_ready  = axi_req.w_valid && (w_cyc >= cfg_w_hold);
            axi_rsp.ar_ready = axi_req.ar_valid && (ar_cyc >= cfg_ar_hold);
            hs_aw = axi_req.aw_valid && axi_rsp.aw_ready;
            hs_w  = axi_req.w_valid && axi_rsp.w_ready;
            hs_ar = axi_req.ar_valid && axi_rsp.ar_ready;
            hs_b  = axi_rsp.b_valid && axi_req.b_ready;
            hs_r  = axi_rsp.r_valid && axi_req.r_ready;
            aw_prev = axi_req.aw;
            w_prev  = axi_req.w;
            ar_prev = axi_req.ar;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: byte-addressed memory, size-aligned accesses only
    task automatic model(input logic wr, input logic [63:0] addr, input logic [1:0] sz,
                         input logic [63:0] data, output logic err, output logic [63:0] rd);
        int n;
        n   = 1 << sz;
        err = (addr % 64'(n)) != 0;
        rd  = '0;
        if (!err) begin
            if (wr) begin
                err = cfg_bresp[1];
                if (!err)
                    for (int i = 0; i < n; i++) mmem[addr + 64'(i)] = data[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd[8*i +: 8] = mget(addr + 64'(i));
                err = cfg_rresp[1] || !cfg_rlast;
            end
        end
    endtask

    task automatic run(input string tag, input logic wr, input logic [63:0] addr,
                       input logic [1:0] sz, input logic [63:0] data, input int stall);
        logic        e_err, lerr, ok;
        logic [63:0] e_rd;
        logic [7:0]  e_strb;
        int          n, off, lat;
        n    = 1 << sz;
        off  = int'(addr[2:0]);
        lerr = (addr % 64'(n)) != 0;
        e_strb = '0;
        for (int i = 0; i < n; i++) if (off + i < 8) e_strb[off + i] = 1'b1;
        model(wr, addr, sz, data, e_err, e_rd);

        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = sz; cmd_data = data;
        rsp_ready = (stall == 0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            tests++; fails++;
            $error("FAIL %s_cmd_timeout: observed cmd_ready 0 expected 1", tag);
            cmd_valid = 1'b0; rsp_ready = 1'b1;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            tests++; fails++;
            $error("FAIL %s_rsp_timeout: observed rsp_valid 0 expected 1", tag);
            rsp_ready = 1'b1;
            return;
        end
        check({tag, "_err"}, 64'(rsp_error), 64'(e_err));
        check({tag, "_data"}, rsp_data, e_rd);
        if (lerr) begin
            check({tag, "_lerr_lat"}, 64'(lat <= 2), 64'd1);
            check({tag, "_no_axi"}, 64'(aw_cyc + w_cyc + ar_cyc), 64'd0);
        end else if (wr) begin
            check({tag, "_aw_addr"}, aw_cap.addr, addr);
            check({tag, "_aw_size"}, 64'(aw_cap.size), 64'(sz));
            check({tag, "_aw_lenburstid"}, {aw_cap.len, 6'b0, aw_cap.burst, aw_cap.id}, {8'd0, 6'b0, 2'b01, 8'd0});
            check({tag, "_w_strb"}, 64'(w_cap.strb), 64'(e_strb));
            check({tag, "_w_data"}, w_cap.data, data << (8 * off));
            check({tag, "_w_last"}, 64'(w_cap.last), 64'd1);
            check({tag, "_aw_cycles"}, 64'(aw_cyc), 64'(cfg_aw_hold));
            check({tag, "_w_cycles"}, 64'(w_cyc), 64'(cfg_w_hold));
        end else begin
            check({tag, "_ar_addr"}, ar_cap.addr, addr);
            check({tag, "_ar_size"}, 64'(ar_cap.size), 64'(sz));
            check({tag, "_ar_cycles"}, 64'(ar_cyc), 64'(cfg_ar_hold));
            check({tag, "_no_aw"}, 64'(aw_cyc + w_cyc), 64'd0);
        end
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({tag, "_stall_hold"}, {rsp_valid, cmd_ready, rsp_error, rsp_data[60:0]},
                  {1'b1, 1'b0, e_err, e_rd[60:0]});
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [63:0] a, d;
        logic [1:0]  s;
        logic        w;
        int          seen;

        #1;
        check("rst_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready,
                             axi_req.r_ready, rsp_valid, cmd_ready}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_err", 64'(rsp_error), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run("wr_qw", 1'b1, 64'h1000, 2'd3, 64'h1122334455667788, 0);
        run("wr_qw2", 1'b1, 64'h2000, 2'd3, 64'hAABBCCDDEEFF0011, 0);
        run("rd_w_2006", 1'b0, 64'h2006, 2'd1, 64'h0, 0);
        run("rd_w_2000", 1'b0, 64'h2000, 2'd1, 64'h0, 0);
        run("wr_b_3003", 1'b1, 64'h3003, 2'd0, 64'h5A, 0);
        run("rd_b_3003", 1'b0, 64'h3003, 2'd0, 64'h0, 0);
        run("rd_dw_misal", 1'b0, 64'h4002, 2'd2, 64'h0, 0);
        run("wr_w_misal", 1'b1, 64'h4001, 2'd1, 64'hBEEF, 0);

        cfg_aw_hold = 3; cfg_w_hold = 1; cfg_bresp = 2'b10;
        run("wr_slverr", 1'b1, 64'h1008, 2'd2, 64'hCAFEF00D, 0);
        cfg_aw_hold = 1; cfg_bresp = 2'b00;

        cfg_rresp = 2'b11; cfg_ar_hold = 2;
        run("rd_decerr", 1'b0, 64'h1000, 2'd2, 64'h0, 0);
        cfg_rresp = 2'b00; cfg_rlast = 1'b0;
        run("rd_nolast", 1'b0, 64'h1004, 2'd2, 64'h0, 0);
        cfg_rlast = 1'b1; cfg_ar_hold = 1;

        // Reset while a read is in flight
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h1000; cmd_size = 2'd3;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (ar_acc) break;
        end
        check("mid_ar_accepted", 64'(ar_acc), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready,
                                 axi_req.r_ready, rsp_valid, cmd_ready}, 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mid_rst_no_rsp", 64'(seen), 64'd0);
        run("post_rst_rd", 1'b0, 64'h2000, 2'd3, 64'h0, 0);

        run("stall_rd", 1'b0, 64'h2004, 2'd2, 64'h0, 5);
        run("after_stall_wr", 1'b1, 64'h2002, 2'd1, 64'h1234, 0);
        run("after_stall_rd", 1'b0, 64'h2000, 2'd3, 64'h0, 0);

        for (int t = 0; t < 40; t++) begin
            cfg_aw_hold = $urandom_range(1, 3);
            cfg_w_hold  = $urandom_range(1, 3);
            cfg_ar_hold = $urandom_range(1, 3);
            cfg_bresp   = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            w = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            a = 64'h6000 + 64'($urandom_range(0, 31));
            d = {$urandom, $urandom};
            run($sformatf("rnd%0d", t), w, a, s, d, 0);
        end

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
